// File: rtl/instr_sequencer.sv
// Program sequencer: fetches ROM words, runs JMP/HALT locally and holds every other
// opcode on `instruction` for one SLOT_CYCLES-long control slot.
module instr_sequencer #(
    parameter int ADDR_W      = 5,
    parameter int SLOT_CYCLES = 3
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              run,
    input  logic              step,
    output logic [ADDR_W-1:0] prog_addr,
    input  logic [7:0]        prog_data,
    output logic [2:0]        instruction,
    output logic [ADDR_W-1:0] operand,
    output logic              ctl_clear,
    output logic              slot_start,
    output logic              busy,
    output logic              halted
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

    localparam logic [2:0] OP_JMP    = 3'b100;
    localparam logic [2:0] OP_HALT   = 3'b101;
    localparam logic [3:0] SLOT_LAST = 4'(SLOT_CYCLES - 1);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [7:0]        ir;
    logic [3:0]        slot_cnt;
    logic              step_mode;

    // A single step only ever buys one word; free-run continues only while run holds.
    logic continue_run;
    assign continue_run = run && !step_mode;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state     <= S_IDLE;
            pc        <= '0;
            ir        <= 8'hA0;
            slot_cnt  <= '0;
            step_mode <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run || step) begin
                        state     <= S_FETCH;
                        step_mode <= !run;
                    end
                end
                S_FETCH: begin
                    case (prog_data[7:5])
                        OP_JMP: begin
                            pc    <= prog_data[ADDR_W-1:0];
                            state <= continue_run ? S_FETCH : S_IDLE;
                        end
                        OP_HALT: state <= S_HALT;
                        default: begin
                            ir       <= prog_data;
                            slot_cnt <= '0;
                            state    <= S_EXEC;
                        end
                    endcase
                end
                S_EXEC: begin
                    slot_cnt <= slot_cnt + 4'd1;
                    // The slot always runs to completion; run is only consulted at its end.
                    if (slot_cnt == SLOT_LAST) begin
                        pc    <= pc + ADDR_W'(1);
                        state <= continue_run ? S_FETCH : S_IDLE;
                    end
                end
                S_HALT: begin
                    if (step) begin
                        pc        <= pc + ADDR_W'(1);
                        step_mode <= 1'b1;
                        state     <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Pure decode of registered state, so no input reaches an output combinationally.
    assign prog_addr   = pc;
    assign operand     = ir[ADDR_W-1:0];
    assign instruction = (state == S_EXEC) ? ir[7:5] : OP_HALT;
    assign ctl_clear   = (state != S_EXEC);
    assign slot_start  = (state == S_EXEC) && (slot_cnt == 4'd0);
    assign busy        = (state == S_FETCH) || (state == S_EXEC);
    assign halted      = (state == S_HALT);
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: per-cycle expected outputs are queued with the
// stimulus and popped against the DUT one cycle at a time.
module tb_instr_sequencer;
    localparam int AW = 5;
    localparam int SC = 3;

    typedef struct packed {
        logic [2:0]    instr;
        logic          clr;
        logic          busy;
        logic          halted;
        logic          sstart;
        logic [AW-1:0] addr;
    } obs_t;

    logic          clk = 1'b0;
    logic          clear_n = 1'b0;
    logic          run = 1'b0;
    logic          step = 1'b0;
    logic [AW-1:0] prog_addr;
    logic [7:0]    prog_data;
    logic [2:0]    instruction;
    logic [AW-1:0] operand;
    logic          ctl_clear, slot_start, busy, halted;

    logic [7:0] rom [32];
    obs_t       exp_q [$];
    int         passed = 0;
    int         total = 0;

    assign prog_data = rom[prog_addr];

    instr_sequencer #(.ADDR_W(AW), .SLOT_CYCLES(SC)) dut (
        .clk(clk), .clear_n(clear_n), .run(run), .step(step),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .instruction(instruction), .operand(operand), .ctl_clear(ctl_clear),
        .slot_start(slot_start), .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic obs_t cur();
        return '{instruction, ctl_clear, busy, halted, slot_start, prog_addr};
    endfunction

    function automatic obs_t mk(logic [2:0] i, logic c, logic b, logic h, logic s, logic [AW-1:0] a);
        return '{i, c, b, h, s, a};
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] want);
        total++;
        assert (got === want) passed++;
        else $error("FAIL %s got %h want %h", tag, got, want);
    endtask

    task automatic push_fetch(logic [AW-1:0] a); exp_q.push_back(mk(3'b101, 1, 1, 0, 0, a)); endtask
    task automatic push_idle(logic [AW-1:0] a);  exp_q.push_back(mk(3'b101, 1, 0, 0, 0, a)); endtask
    task automatic push_halt(logic [AW-1:0] a);  exp_q.push_back(mk(3'b101, 1, 0, 1, 0, a)); endtask
    task automatic push_exec(logic [2:0] op, logic [AW-1:0] a);
        for (int i = 0; i < SC; i++) exp_q.push_back(mk(op, 0, 1, 0, (i == 0), a));
    endtask

    task automatic tick(string tag, int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) check({tag, "_underflow"}, 32'd1, 32'd0);
            else check(tag, 32'(cur()), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic tick_all(string tag);
        tick(tag, exp_q.size());
    endtask

    task automatic do_reset(string tag);
        run = 1'b0;
        step = 1'b0;
        clear_n = 1'b0;
        #2;
        check({tag, "_rst"}, 32'(cur()), 32'(mk(3'b101, 1, 0, 0, 0, '0)));
        check({tag, "_rst_opnd"}, 32'(operand), 32'd0);
        exp_q.delete();
        clear_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 8'hA0;

        // Free-run three words ending in HALT; run+step together acts as run.
        do_reset("t1");
        rom[0] = 8'h60; rom[1] = 8'h40; rom[2] = 8'hA0; rom[3] = 8'hC0;
        run = 1'b1; step = 1'b1;
        push_fetch(0);
        tick("t1_start", 1);
        step = 1'b0;
        push_exec(3'b011, 0); push_fetch(1); push_exec(3'b010, 1); push_fetch(2);
        push_halt(2); push_halt(2); push_halt(2);
        tick_all("t1_run");
        // Step out of HALT: pc advances, one word executes, then IDLE.
        run = 1'b0; step = 1'b1;
        push_fetch(3);
        tick("t1_hstep", 1);
        step = 1'b0;
        push_exec(3'b110, 3); push_idle(4);
        tick_all("t1_hexec");

        // JMP skips address 1.
        do_reset("t2");
        rom[0] = 8'h83; rom[1] = 8'h20; rom[3] = 8'hE0; rom[4] = 8'hA0;
        run = 1'b1;
        push_fetch(0); push_fetch(3); push_exec(3'b111, 3); push_fetch(4); push_halt(4);
        tick_all("t2_jmp");

        // Single step; a step in the last EXEC cycle is ignored.
        do_reset("t3");
        rom[0] = 8'h2B; rom[1] = 8'h40;
        step = 1'b1;
        push_fetch(0);
        tick("t3_step", 1);
        step = 1'b0;
        push_exec(3'b001, 0); push_idle(1); push_idle(1);
        tick("t3_exec", SC - 1);
        step = 1'b1;
        tick("t3_last", 1);
        step = 1'b0;
        tick_all("t3_idle");
        check("t3_operand", 32'(operand), 32'd11);

        // PC wrap from 31 to 0, then a JMP with run dropped exits to IDLE.
        do_reset("t4");
        rom[0] = 8'h9F; rom[31] = 8'h00;
        run = 1'b1;
        push_fetch(0); push_fetch(31); push_exec(3'b000, 31); push_fetch(0);
        tick_all("t4_wrap");
        run = 1'b0;
        push_idle(31);
        tick_all("t4_jmpexit");

        // Drop run in the 2nd EXEC cycle, then async clear mid-EXEC.
        do_reset("t5");
        rom[0] = 8'h60; rom[1] = 8'h40;
        run = 1'b1;
        push_fetch(0); push_exec(3'b011, 0); push_idle(1);
        tick("t5_pre", 3);
        run = 1'b0;
        tick_all("t5_drop");
        run = 1'b1;
        push_fetch(1); push_exec(3'b010, 1);
        tick("t5_rerun", 2);
        exp_q.delete();
        #2;
        clear_n = 1'b0;
        #1;
        check("t5_async", 32'(cur()), 32'(mk(3'b101, 1, 0, 0, 0, '0)));
        run = 1'b0;
        #1;
        clear_n = 1'b1;
        push_idle(0);
        tick_all("t5_after");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Program sequencer sitting directly upstream of the control unit. Fetches 8-bit program words from an external combinational program ROM and decodes the opcode/operand fields. Holds each 3-bit opcode stable on `instruction` for one full control slot and keeps the control unit's state machine aligned to that slot via `ctl_clear`. Two opcodes the control unit treats as idle are executed locally: JMP (3'b100) and HALT (3'b101).

## Interface
- `ADDR_W`, 5: program address width; also the operand width.
- `SLOT_CYCLES`, 3: clock cycles per executed instruction. Matches the control unit's s0→s1→s2 cycle; legal range 2–15.
- `clk`  in  1  system clock; all state updates on rising edge.
- `clear_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; 1 = free-running execution.
- `step`  in  1  one-cycle pulse; execute exactly one program word when idle or halted.
- `prog_addr`  out  ADDR_W  ROM address (= `pc`).
- `prog_data`  in  8  ROM word, combinational from `prog_addr`; [7:5] opcode, [ADDR_W-1:0] operand.
- `instruction`  out  3  opcode to the control unit; 3'b101 (idle) outside EXEC.
- `operand`  out  ADDR_W  operand field of the latched word.
- `ctl_clear`  out  1  active-high clear for the control unit; 0 only during EXEC.
- `slot_start`  out  1  1 in the first EXEC cycle.
- `busy`  out  1  1 in FETCH or EXEC.
- `halted`  out  1  1 in HALT.

## Operation
- Registers: `pc` (ADDR_W bits), `ir` (8 bits), `slot_cnt` (4 bits), `step_mode` (1 bit), FSM state.
- States and transitions:
  - IDLE → FETCH when `run`=1 or `step`=1. Set `step_mode` = !`run`.
  - FETCH (1 cycle) samples `prog_data` at `prog_addr`=`pc`:
    - Opcode 3'b100 (JMP): `pc` ← operand; `ir` is unchanged. Next state is FETCH if `run`=1 and `step_mode`=0, otherwise IDLE.
    - Opcode 3'b101 (HALT): `pc` is held; next state is HALT.
    - Any other opcode: `ir` ← `prog_data`, `slot_cnt` ← 0, next state is EXEC.
  - EXEC: `slot_cnt` increments every cycle. When `slot_cnt` = SLOT_CYCLES-1: `pc` ← `pc`+1 (wraps 2^ADDR_W-1 → 0). Next state is FETCH if `run`=1 and `step_mode`=0, otherwise IDLE.
  - HALT: `step`=1 → `pc` ← `pc`+1, `step_mode` ← 1, go to FETCH. `run` has no effect in HALT.
- Output decode:
  - `instruction` = `ir`[7:5] in EXEC, else 3'b101.
  - `operand` = `ir`[ADDR_W-1:0] at all times.
  - `ctl_clear` = 1 in every state except EXEC.
- Boundary behaviour:
  - `run` dropped mid-EXEC: the slot is never truncated. It completes, then the FSM goes to IDLE.
  - `step` outside IDLE/HALT is ignored, including when it coincides with the last EXEC cycle.
  - `run`=1 and `step`=1 together in IDLE: treated as run (`step_mode`=0).
  - Jump to self with `run`=1 loops in FETCH; dropping `run` exits to IDLE after the current fetch.
  - A jump to the address after wrap behaves identically to any other jump.
  - `clear_n` low mid-operation immediately forces all reset values. `ctl_clear` rises immediately, which forces the control unit to s0.
- Reset values:
  - state = IDLE, `pc` = 0, `ir` = 8'hA0, `slot_cnt` = 0, `step_mode` = 0.
  - Outputs: `instruction` = 3'b101, `operand` = 0, `ctl_clear` = 1, `slot_start` = 0, `busy` = 0, `halted` = 0, `prog_addr` = 0.

## Timing
- All outputs are decoded from registered state; there are no combinational paths from inputs to outputs.
- Control unit alignment: `ctl_clear` falls after the rising edge that enters EXEC. The control unit leaves s0 on the following falling edge. s0/s1/s2 therefore each occupy one cycle within the SLOT_CYCLES=3 slot.
- Per-instruction cost:
  - Executed word: 1 FETCH + SLOT_CYCLES EXEC cycles. In free-run this gives 4 cycles per instruction at the default.
  - JMP: 1 cycle, with no EXEC.
- `step` to `busy`=1: 1 cycle. `slot_start` asserts 2 cycles after the `step` edge.
- HALT is entered 1 cycle after the HALT word's fetch; `halted` asserts on that edge.

## Test plan
- Reset, then `run`=1 with ROM {0:8'h60, 1:8'h40, 2:8'hA0} → `instruction` shows 3'b011 for 3 cycles, then 3'b101 for 1 cycle, then 3'b010 for 3 cycles. `halted`=1 with `pc`=2; `ctl_clear` is low only during the two EXEC slots.
- `run`=1, ROM {0:8'h83 (JMP 3), 3:8'hE0} → `prog_addr` sequence is 0, 3. `instruction` = 3'b111 in EXEC; address 1 is never fetched.
- `run`=0, one `step` pulse at ROM 0:8'h20 → exactly one 3-cycle EXEC with `instruction`=3'b001, then IDLE with `pc`=1. A second `step` during EXEC is ignored.
- `pc`=31, word 8'h00, `run`=1 → after EXEC, `pc`=0 (wrap); next fetch is at address 0.
- Drop `run` in the 2nd EXEC cycle → the slot completes 3 cycles, then IDLE. Assert `clear_n`=0 mid-EXEC → `instruction`=3'b101, `ctl_clear`=1, `pc`=0 immediately, without waiting for a clock edge.
